mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_watchdog.sv | 46 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    // Arbiter phases: idle contest, open slave transaction, one-cycle gap.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_COOLDOWN = 2'd2
    } arb_state_e;

    // Index of a master (two masters, so a single bit).
    typedef logic master_idx_t;

    // Read data returned to the granted master when the watchdog fires.
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    // Width of the watchdog counter; covers the full 1..65535 limit range.
    localparam int unsigned WDOG_W = 16;

    // Round-robin pick: with both masters requesting the one that did not
    // win last time gets the slave; a lone requester always wins.
    function automatic master_idx_t pick_winner(input logic        sel0,
                                                input logic        sel1,
                                                input master_idx_t last);
        if (sel0 && sel1) begin
            return ~last;
        end
        return sel1 ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Slave-ack watchdog: counts BUSY cycles without an ack and flags the cycle
// on which the TIMEOUT_CYCLES-th such cycle is reached. Only instantiated
// when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);

    // The count equals (BUSY cycle number - 1), so the limit is hit on the
    // TIMEOUT_CYCLES-th BUSY cycle when count == TIMEOUT_CYCLES - 1.
    localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    assign expired_o = busy_i && (count_q == LIMIT_M1);

    // Next count: cleared outside BUSY, advances on every unacknowledged BUSY cycle.
    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        count_d = count_q;
        if (!busy_i) begin
            count_d = '0;
        end else if (!ack_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to enable the slave-ack
// watchdog (timeout ack with err_o and 0xDEADBEEF read data). Without it
// err_o is tied low and a transaction waits for s_ack_i indefinitely.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n_i,
    // master 0
    input  logic        m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_wr_mask_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    // master 1
    input  logic        m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_wr_mask_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    // shared slave
    output logic        s_sel_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_wr_mask_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    // status
    output logic        grant_o,
    output logic        busy_o,
    output logic        err_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_e  state_q;
    master_idx_t grant_q;

    logic        busy;
    logic        ack_ok;
    logic        timeout_hit;
    logic        txn_done;
    logic [31:0] rd_data;

    assign busy = (state_q == ST_BUSY);

    // A real slave ack always wins over a watchdog expiry in the same cycle.
    assign ack_ok = busy && s_ack_i;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic wdog_expired;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .busy_i    (busy),
        .ack_i     (s_ack_i),
        .expired_o (wdog_expired)
    );

    assign timeout_hit = wdog_expired && !s_ack_i;
`else
    assign timeout_hit = 1'b0;
`endif

    assign txn_done = ack_ok || timeout_hit;

    // Arbitration and transaction sequencing.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // Grant resets to master 1 so master 0 wins the first contest.
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_sel_i || m1_sel_i) begin
                        grant_q <= pick_winner(m0_sel_i, m1_sel_i, grant_q);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (txn_done) begin
                        state_q <= ST_COOLDOWN;
                    end
                end
                // One dead cycle lets the acked master deassert its registered sel.
                ST_COOLDOWN: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Slave request: sel gated by BUSY, payload always muxed from the grant register.
    always_comb begin
        s_sel_o     = busy && (grant_q ? m1_sel_i : m0_sel_i);
        s_addr_o    = grant_q ? m1_addr_i    : m0_addr_i;
        s_we_o      = grant_q ? m1_we_i      : m0_we_i;
        s_wr_mask_o = grant_q ? m1_wr_mask_i : m0_wr_mask_i;
        s_data_o    = grant_q ? m1_data_i    : m0_data_i;
    end

    // Master responses: the ack passes straight through in the slave's ack
    // cycle, so it cannot be registered without adding a cycle of latency.
    always_comb begin
        m0_ack_o = txn_done && (grant_q == 1'b0);
        m1_ack_o = txn_done && (grant_q == 1'b1);
        rd_data  = timeout_hit ? ERR_DATA : s_data_i;
    end

    assign m0_data_o = rd_data;
    assign m1_data_o = rd_data;
    assign grant_o   = grant_q;
    assign busy_o    = busy;
    assign err_o     = timeout_hit;

endmodule
